// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
//
// In-order controller that sequences updates to a 2-bit branch predictor.
// Decode allocates one queue entry per predicted branch; execute resolves
// entries out of order by tag; the oldest resolved entry retires each cycle
// and produces one registered predictor update. A retiring mispredict
// raises a one-cycle flush, discards every younger (wrong-path) entry and
// holds allocation off for one extra FLUSH cycle.
//
// Handshake: alloc fires on a cycle where alloc_valid && alloc_ready at the
// rising clock edge. alloc_ready is a combinational function of queue state
// only and never depends on alloc_valid. alloc_tag is valid whenever
// alloc_ready is high. res_valid is a single-cycle strobe with no ready.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   alloc_valid       decode presents a predicted branch
//   alloc_pred_taken  predicted direction of that branch
//   alloc_ready       an entry is available to allocate
//   alloc_tag         tag given to the allocating branch (tail pointer)
//   res_valid         execute resolves a branch
//   res_tag           tag being resolved
//   res_taken         actual direction
//   bp_update_we      one-cycle predictor update pulse
//   bp_update_taken   actual direction for the update
//   mispredict        one-cycle flush pulse to the front end
//   bq_count          occupied entries
//   state_dbg         FSM state (0 = RUN, 1 = FLUSH)
// -----------------------------------------------------------------------------
module branch_resolve_ctrl #(
    parameter int BQ_DEPTH = 8,
    parameter int TAG_W    = $clog2(BQ_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_valid,
    input  logic             alloc_pred_taken,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,
    output logic             bp_update_we,
    output logic             bp_update_taken,
    output logic             mispredict,
    output logic [TAG_W:0]   bq_count,
    output logic             state_dbg
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(BQ_DEPTH);

    state_t              state;
    logic [BQ_DEPTH-1:0] ent_valid;
    logic [BQ_DEPTH-1:0] ent_resolved;
    logic [BQ_DEPTH-1:0] ent_pred;
    logic [BQ_DEPTH-1:0] ent_actual;
    logic [TAG_W-1:0]    head;
    logic [TAG_W-1:0]    tail;

    logic retire;
    logic retire_mispredict;
    logic alloc_fire;
    logic res_accept;

    always_comb begin
        // Retire looks only at registered resolved bits, so a resolve that
        // lands on the head entry this cycle retires on the next cycle.
        retire            = (state == ST_RUN) && ent_valid[head] && ent_resolved[head];
        retire_mispredict = retire && (ent_actual[head] != ent_pred[head]);
        // A full queue cannot take an alloc even while retiring (no bypass),
        // and a mispredicting retire blocks any same-cycle alloc because
        // that branch would be on the wrong path.
        alloc_ready       = (bq_count != FULL_COUNT) && (state == ST_RUN) && !retire_mispredict;
        alloc_fire        = alloc_valid && alloc_ready;
        // First result wins: repeat resolves and resolves to empty slots
        // are dropped, as is everything during FLUSH.
        res_accept        = (state == ST_RUN) && res_valid
                            && ent_valid[res_tag] && !ent_resolved[res_tag];
    end

    assign alloc_tag = tail;
    assign state_dbg = (state == ST_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_RUN;
            ent_valid       <= '0;
            ent_resolved    <= '0;
            ent_pred        <= '0;
            ent_actual      <= '0;
            head            <= '0;
            tail            <= '0;
            bq_count        <= '0;
            bp_update_we    <= 1'b0;
            bp_update_taken <= 1'b0;
            mispredict      <= 1'b0;
        end else begin
            bp_update_we    <= retire;
            bp_update_taken <= retire & ent_actual[head];
            mispredict      <= retire_mispredict;

            case (state)
                ST_RUN:   if (retire_mispredict) state <= ST_FLUSH;
                ST_FLUSH: state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase

            if (retire_mispredict) begin
                // Every remaining entry is younger than the mispredict.
                ent_valid    <= '0;
                ent_resolved <= '0;
                head         <= '0;
                tail         <= '0;
                bq_count     <= '0;
            end else begin
                // The three updates never touch the same slot: a resolve
                // needs an unresolved entry while retire needs a resolved
                // one, and alloc writes tail which equals head only when the
                // queue is empty (no retire) or full (no alloc).
                if (res_accept) begin
                    ent_resolved[res_tag] <= 1'b1;
                    ent_actual[res_tag]   <= res_taken;
                end
                if (retire) begin
                    ent_valid[head]    <= 1'b0;
                    ent_resolved[head] <= 1'b0;
                    head               <= head + TAG_W'(1);
                end
                if (alloc_fire) begin
                    ent_valid[tail]    <= 1'b1;
                    ent_resolved[tail] <= 1'b0;
                    ent_pred[tail]     <= alloc_pred_taken;
                    ent_actual[tail]   <= 1'b0;
                    tail               <= tail + TAG_W'(1);
                end
                bq_count <= bq_count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
//
// Directed bench for branch_resolve_ctrl. Inputs change 1 ns after each rising
// edge; outputs are checked in the same window, so they show the registered
// state from the last edge plus combinational response to the new inputs.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;

    localparam int BQ_DEPTH = 8;
    localparam int TAG_W    = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             alloc_valid;
    logic             alloc_pred_taken;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic             res_taken;
    logic             bp_update_we;
    logic             bp_update_taken;
    logic             mispredict;
    logic [TAG_W:0]   bq_count;
    logic             state_dbg;

    branch_resolve_ctrl #(.BQ_DEPTH(BQ_DEPTH), .TAG_W(TAG_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .alloc_valid      (alloc_valid),
        .alloc_pred_taken (alloc_pred_taken),
        .alloc_ready      (alloc_ready),
        .alloc_tag        (alloc_tag),
        .res_valid        (res_valid),
        .res_tag          (res_tag),
        .res_taken        (res_taken),
        .bp_update_we     (bp_update_we),
        .bp_update_taken  (bp_update_taken),
        .mispredict       (mispredict),
        .bq_count         (bq_count),
        .state_dbg        (state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid      = 1'b0;
        alloc_pred_taken = 1'b0;
        res_valid        = 1'b0;
        res_tag          = '0;
        res_taken        = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic alloc(input logic pred, input int exp_tag, input string tag);
        alloc_valid      = 1'b1;
        alloc_pred_taken = pred;
        check({tag, "_ready"}, 32'(alloc_ready), 32'd1);
        check({tag, "_tag"}, 32'(alloc_tag), 32'(exp_tag));
        tick();
        alloc_valid = 1'b0;
    endtask

    task automatic resolve(input int t, input logic taken);
        res_valid = 1'b1;
        res_tag   = TAG_W'(t);
        res_taken = taken;
        tick();
        res_valid = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    initial begin
        idle_inputs();
        rst = 1'b0;

        // Reset state
        do_reset();
        check("rst_ready", 32'(alloc_ready), 32'd1);
        check("rst_tag",   32'(alloc_tag),   32'd0);
        check("rst_count", 32'(bq_count),    32'd0);
        check("rst_we",    32'(bp_update_we), 32'd0);
        check("rst_misp",  32'(mispredict),  32'd0);
        check("rst_state", 32'(state_dbg),   32'd0);

        // 1: single correct branch, update two cycles after resolve
        alloc(1'b1, 0, "t1_a0");
        check("t1_count1", 32'(bq_count), 32'd1);
        resolve(0, 1'b1);
        check("t1_we_early", 32'(bp_update_we), 32'd0);
        tick();
        check("t1_we",    32'(bp_update_we),    32'd1);
        check("t1_taken", 32'(bp_update_taken), 32'd1);
        check("t1_misp",  32'(mispredict),      32'd0);
        check("t1_count", 32'(bq_count),        32'd0);
        tick();
        check("t1_we_off", 32'(bp_update_we), 32'd0);

        // 2: fill, full, retire without bypass, wrap of tail
        do_reset();
        for (int i = 0; i < BQ_DEPTH; i++) alloc(1'b1, i, "t2_fill");
        alloc_valid = 1'b1;
        check("t2_full_ready", 32'(alloc_ready), 32'd0);
        check("t2_full_count", 32'(bq_count),    32'd8);
        res_valid = 1'b1; res_tag = 3'd0; res_taken = 1'b1;
        tick();
        res_valid = 1'b0;
        check("t2_retire_ready", 32'(alloc_ready), 32'd0);
        check("t2_retire_count", 32'(bq_count),    32'd8);
        tick();
        check("t2_we",        32'(bp_update_we), 32'd1);
        check("t2_count7",    32'(bq_count),     32'd7);
        check("t2_ready",     32'(alloc_ready),  32'd1);
        check("t2_wrap_tag",  32'(alloc_tag),    32'd0);
        tick();
        alloc_valid = 1'b0;
        check("t2_refill", 32'(bq_count), 32'd8);
        check("t2_tag1",   32'(alloc_tag), 32'd1);

        // 3: out-of-order resolve, in-order updates on consecutive cycles
        do_reset();
        alloc(1'b1, 0, "t3_a0");
        alloc(1'b0, 1, "t3_a1");
        alloc(1'b1, 2, "t3_a2");
        resolve(2, 1'b1);
        check("t3_we_r2", 32'(bp_update_we), 32'd0);
        resolve(1, 1'b0);
        check("t3_we_r1", 32'(bp_update_we), 32'd0);
        resolve(0, 1'b1);
        check("t3_we_r0", 32'(bp_update_we), 32'd0);
        tick();
        check("t3_we0",    32'(bp_update_we),    32'd1);
        check("t3_tk0",    32'(bp_update_taken), 32'd1);
        tick();
        check("t3_we1",    32'(bp_update_we),    32'd1);
        check("t3_tk1",    32'(bp_update_taken), 32'd0);
        tick();
        check("t3_we2",    32'(bp_update_we),    32'd1);
        check("t3_tk2",    32'(bp_update_taken), 32'd1);
        check("t3_misp",   32'(mispredict),      32'd0);
        tick();
        check("t3_we_end", 32'(bp_update_we), 32'd0);
        check("t3_count",  32'(bq_count),     32'd0);

        // 4: mispredict flush
        do_reset();
        for (int i = 0; i < 4; i++) alloc(1'b0, i, "t4_fill");
        resolve(0, 1'b1);
        alloc_valid = 1'b1;
        check("t4_ready_retire", 32'(alloc_ready), 32'd0);
        tick();
        res_valid = 1'b1; res_tag = 3'd2; res_taken = 1'b0;
        check("t4_we",          32'(bp_update_we),    32'd1);
        check("t4_taken",       32'(bp_update_taken), 32'd1);
        check("t4_misp",        32'(mispredict),      32'd1);
        check("t4_count",       32'(bq_count),        32'd0);
        check("t4_state_flush", 32'(state_dbg),       32'd1);
        check("t4_ready_flush", 32'(alloc_ready),     32'd0);
        tick();
        alloc_valid = 1'b0;
        check("t4_misp_off",  32'(mispredict),  32'd0);
        check("t4_state_run", 32'(state_dbg),   32'd0);
        check("t4_ready_run", 32'(alloc_ready), 32'd1);
        check("t4_tag0",      32'(alloc_tag),   32'd0);
        resolve(2, 1'b0);
        tick();
        check("t4_stale_we",    32'(bp_update_we), 32'd0);
        tick();
        check("t4_stale_we2",   32'(bp_update_we), 32'd0);
        check("t4_stale_count", 32'(bq_count),     32'd0);

        // 5: ignored resolves keep original result
        do_reset();
        alloc(1'b0, 0, "t5_a0");
        alloc(1'b1, 1, "t5_a1");
        resolve(5, 1'b1);
        check("t5_bogus_count", 32'(bq_count),     32'd2);
        check("t5_bogus_we",    32'(bp_update_we), 32'd0);
        resolve(1, 1'b1);
        resolve(1, 1'b0);
        check("t5_rep_we", 32'(bp_update_we), 32'd0);
        resolve(0, 1'b0);
        tick();
        check("t5_we0",   32'(bp_update_we),    32'd1);
        check("t5_tk0",   32'(bp_update_taken), 32'd0);
        check("t5_misp0", 32'(mispredict),      32'd0);
        tick();
        check("t5_we1",   32'(bp_update_we),    32'd1);
        check("t5_tk1",   32'(bp_update_taken), 32'd1);
        check("t5_misp1", 32'(mispredict),      32'd0);
        tick();
        check("t5_count", 32'(bq_count), 32'd0);

        // 6: reset with resolved entries pending
        do_reset();
        for (int i = 0; i < 3; i++) alloc(1'b1, i, "t6_fill");
        resolve(2, 1'b1);
        resolve(1, 1'b1);
        resolve(0, 1'b1);
        rst = 1'b1;
        tick();
        check("t6_we",    32'(bp_update_we), 32'd0);
        check("t6_count", 32'(bq_count),     32'd0);
        check("t6_ready", 32'(alloc_ready),  32'd1);
        check("t6_tag",   32'(alloc_tag),    32'd0);
        rst = 1'b0;
        tick();
        check("t6_we_after", 32'(bp_update_we), 32'd0);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
